// File: rtl/uart_rx_buffer.sv
// UART receive path: 2-flop rx synchronizer, 16x oversampling receiver and a byte FIFO,
// seen by the CPU as DATA/STATUS registers. Define UART_RX_PARITY_EN for 8E1 framing (default 8N1).
module uart_rx_buffer #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int DEPTH     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  input  logic        reg_sel,
  input  logic        wenable,
  input  logic [7:0]  wdata,
  output logic [31:0] rdata,
  output logic        int_pending
);

  // Handshake: no valid/ready pairs here. A pop is a single-cycle wenable with
  // reg_sel=0; the receiver pushes for one cycle when a good stop bit is sampled.

  localparam int DIV_RAW = (CLK_FREQ + BAUD_RATE * 8) / (BAUD_RATE * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW      = $clog2(DEPTH);
  localparam logic [CW-1:0] TICK_LAST = CW'(DIV - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_AFTER_DATA = S_PARITY;
`else
  localparam logic [2:0] S_AFTER_DATA = S_STOP;
`endif

  logic          sync1_q, rx_s;
  logic [CW-1:0] tick_cnt_q;
  logic          tick;
  logic [2:0]    state_q;
  logic [3:0]    sample_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          par_bad;
  logic          stop_sample, push;

  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wptr_q, rptr_q, count;
  logic          empty, full, do_pop, do_push;
  logic          overrun_q, frame_err_q, parity_err;
  logic          clr_sel;
  logic [7:0]    count8;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_q <= rx;
      rx_s    <= sync1_q;
    end
  end

  // Free-running oversample tick; only rst_n restarts it.
  assign tick = (tick_cnt_q == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else           tick_cnt_q <= tick_cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sample_q <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
    end else if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_q  <= S_START;
            sample_q <= '0;
          end
        end
        S_START: begin
          // Mid-start-bit check rejects short low glitches.
          if (sample_q == 4'd7) begin
            sample_q <= '0;
            bit_q    <= '0;
            state_q  <= rx_s ? S_IDLE : S_DATA;
          end else begin
            sample_q <= sample_q + 4'd1;
          end
        end
        S_DATA: begin
          sample_q <= sample_q + 4'd1;
          if (sample_q == 4'd15) begin
            shift_q <= {rx_s, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= S_AFTER_DATA;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          sample_q <= sample_q + 4'd1;
          if (sample_q == 4'd15) state_q <= S_STOP;
        end
`endif
        S_STOP: begin
          sample_q <= sample_q + 4'd1;
          if (sample_q == 4'd15) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad_q;
  logic parity_err_q;
  logic unused_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      par_bad_q <= 1'b0;
    else if (tick && state_q == S_PARITY && sample_q == 4'd15)
      par_bad_q <= ^{shift_q, rx_s};
  end

  assign par_bad = par_bad_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err_q <= 1'b0;
    else        parity_err_q <= (stop_sample & par_bad) | (parity_err_q & ~(clr_sel & wdata[3]));
  end

  assign parity_err   = parity_err_q;
  assign unused_wdata = ^{wdata[7:4], wdata[0]};
`else
  logic unused_wdata;
  assign par_bad      = 1'b0;
  assign parity_err   = 1'b0;
  assign unused_wdata = ^{wdata[7:3], wdata[0]};
`endif

  assign stop_sample = tick && (state_q == S_STOP) && (sample_q == 4'd15);
  assign push        = stop_sample && rx_s && !par_bad;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = wenable && !reg_sel && !empty;
  // A pop in the same cycle frees the slot the push is about to use.
  assign do_push = push && (!full || do_pop);
  assign clr_sel = wenable && reg_sel;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= shift_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
      overrun_q   <= (push & full & ~do_pop) | (overrun_q & ~(clr_sel & wdata[1]));
      frame_err_q <= (stop_sample & ~rx_s) | (frame_err_q & ~(clr_sel & wdata[2]));
    end
  end

  assign count       = wptr_q - rptr_q;
  assign count8      = 8'(count);
  assign int_pending = !empty;

  always_comb begin
    rdata = '0;
    if (reg_sel) begin
      rdata[0]    = !empty;
      rdata[1]    = overrun_q;
      rdata[2]    = frame_err_q;
      rdata[3]    = parity_err;
      rdata[15:8] = count8;
    end else if (!empty) begin
      rdata[7:0] = mem[rptr_q[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer: directed cases plus random traffic,
// compared against a queue-based model of the received byte stream and flags.
module tb_uart_rx_buffer;

  localparam int CLK_FREQ  = 1_600_000;
  localparam int BAUD_RATE = 100_000;
  localparam int DEPTH     = 4;
  localparam int BIT_CLKS  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        reg_sel = 1'b0;
  logic        wenable = 1'b0;
  logic [7:0]  wdata = '0;
  logic [31:0] rdata;
  logic        int_pending;

  uart_rx_buffer #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .reg_sel(reg_sel), .wenable(wenable),
    .wdata(wdata), .rdata(rdata), .int_pending(int_pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic m_over = 1'b0, m_frame = 1'b0, m_par = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = '0;
    s[0] = (exp_q.size() != 0);
    s[1] = m_over;
    s[2] = m_frame;
    s[3] = m_par;
    s[15:8] = 8'(exp_q.size());
    return s;
  endfunction

  function automatic logic [31:0] model_data();
    if (exp_q.size() == 0) return 32'h0;
    return {24'h0, exp_q[0]};
  endfunction

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  task automatic read_reg(input logic sel, output logic [31:0] v);
    @(negedge clk);
    reg_sel = sel;
    #1 v = rdata;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] v;
    read_reg(1'b1, v);
    check_eq({tag, "_status"}, v, model_status());
    read_reg(1'b0, v);
    check_eq({tag, "_data"}, v, model_data());
    check_eq({tag, "_int"}, {31'h0, int_pending}, {31'h0, exp_q.size() != 0});
  endtask

  task automatic pop_head();
    @(negedge clk);
    reg_sel = 1'b0;
    wdata   = $urandom_range(0, 255);
    wenable = 1'b1;
    @(negedge clk);
    wenable = 1'b0;
    wdata   = '0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic write_status(input logic [7:0] v);
    @(negedge clk);
    reg_sel = 1'b1;
    wdata   = v;
    wenable = 1'b1;
    @(negedge clk);
    wenable = 1'b0;
    wdata   = '0;
    if (v[1]) m_over = 1'b0;
    if (v[2]) m_frame = 1'b0;
`ifdef UART_RX_PARITY_EN
    if (v[3]) m_par = 1'b0;
`endif
  endtask

  // Drive one frame on rx and update the model with what the frame should do.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par, input int idle_bits);
    logic bad;
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    repeat (BIT_CLKS) @(negedge clk);
    bad = ^{d, par};
`else
    bad = 1'b0 & par;
`endif
    rx = stop;
    repeat (BIT_CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (idle_bits * BIT_CLKS) @(negedge clk);
    if (bad) m_par = 1'b1;
    if (!stop) m_frame = 1'b1;
    if (stop && !bad) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else m_over = 1'b1;
    end
  endtask

  task automatic send_good(input logic [7:0] d, input int idle_bits);
    send_frame(d, 1'b1, even_par(d), idle_bits);
  endtask

  initial begin
    logic [7:0] b;
    logic [31:0] v;

    repeat (3) @(negedge clk);
    check_eq("reset_int_low", {31'h0, int_pending}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_all("reset");

    // Single byte, then pop
    send_good(8'hA5, 1);
    read_reg(1'b1, v);
    check_eq("a5_status_const", v, 32'h0000_0101);
    read_reg(1'b0, v);
    check_eq("a5_data_const", v, 32'h0000_00A5);
    check_all("a5");
    pop_head();
    read_reg(1'b1, v);
    check_eq("a5_popped_status", v, 32'h0);
    check_all("a5_pop");

    // Back-to-back frames and in-order pops
    send_good(8'h01, 0);
    send_good(8'h02, 0);
    send_good(8'h03, 1);
    check_all("b2b");
    for (int i = 0; i < 3; i++) begin
      read_reg(1'b0, v);
      check_eq("b2b_order", v, 32'(i + 1));
      pop_head();
    end
    pop_head();
    check_all("empty_pop");
    read_reg(1'b0, v);
    check_eq("empty_no_x", {31'h0, $isunknown(v)}, 32'h0);

    // Overrun on a full FIFO
    for (int i = 0; i < 5; i++) send_good(8'(8'h11 + i), 0);
    repeat (BIT_CLKS) @(negedge clk);
    check_all("overrun");
    write_status(8'h02);
    check_all("overrun_clr");
    for (int i = 0; i < 4; i++) begin
      pop_head();
      check_all("overrun_drain");
    end

    // Framing error then a good byte
    send_frame(8'h3C, 1'b0, even_par(8'h3C), 2);
    check_all("frame_err");
    send_good(8'h55, 1);
    check_all("after_frame_err");
    write_status(8'h04);
    pop_head();
    check_all("frame_clr");

    // Start-bit glitch of 4 clocks
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    check_all("glitch");

    // Reset in the middle of data bit 4 with two bytes buffered
    send_good(8'hC3, 0);
    send_good(8'h3D, 1);
    check_all("pre_reset");
    b = 8'h5A;
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = b[4];
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst_n = 1'b0;
    #1 check_eq("async_reset_int", {31'h0, int_pending}, 32'h0);
    repeat (3) @(negedge clk);
    rx = 1'b1;
    rst_n = 1'b1;
    exp_q.delete();
    m_over = 1'b0;
    m_frame = 1'b0;
    m_par = 1'b0;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check_all("post_reset");
    send_good(8'h7E, 1);
    check_all("post_reset_7e");
    pop_head();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 1);
    check_all("parity_bad");
    send_frame(8'h07, 1'b1, 1'b1, 1);
    check_all("parity_good");
    write_status(8'h08);
    pop_head();
    check_all("parity_clr");
`endif

    // Random traffic
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          b = 8'($urandom_range(0, 255));
          send_frame(b, ($urandom_range(0, 7) != 0), even_par(b), $urandom_range(0, 2));
        end
        2: pop_head();
        default: write_status(8'($urandom_range(0, 255)));
      endcase
      check_all("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
